// File: rtl/gray_quad_pkg.sv
// Shared types and Gray-sequence helpers for the 2-bit Gray/quadrature decoder.
package gray_quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic [1:0] G00 = 2'b00;
  localparam logic [1:0] G01 = 2'b01;
  localparam logic [1:0] G11 = 2'b11;
  localparam logic [1:0] G10 = 2'b10;

  function automatic logic [1:0] gray_next_up(input logic [1:0] g);
    case (g)
      G00:     return G01;
      G01:     return G11;
      G11:     return G10;
      default: return G00;
    endcase
  endfunction

  function automatic step_t gray_step(input logic [1:0] old_g, input logic [1:0] new_g);
    if (old_g == new_g) return STEP_NONE;
    // Both bits flipping cannot come from a single Gray step.
    if ((old_g ^ new_g) == 2'b11) return STEP_ILLEGAL;
    if (new_g == gray_next_up(old_g)) return STEP_UP;
    return STEP_DOWN;
  endfunction

endpackage

// File: rtl/gray_sync_filter.sv
// Two-flop synchronizer plus stability filter for a 2-bit asynchronous bus.
// accept is combinational: at the edge where it is high, filt takes cand.
module gray_sync_filter
  import gray_quad_pkg::*;
#(
  parameter int FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sync_in,
  input  logic       capture_any,
  output logic [1:0] filt,
  output logic [1:0] cand,
  output logic       accept
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LOAD = CW'(FILT_LEN - 1);

  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          pending;

  // The cycle right after reset is not counted as a hold cycle.
  assign pending = capture_any || (s2 != filt);
  assign accept  = armed && pending && (cnt == '0);
  assign cand    = s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= G00;
      s2    <= G00;
      filt  <= G00;
      cnt   <= LOAD;
      armed <= 1'b0;
    end else begin
      s1    <= sync_in;
      s2    <= s1;
      armed <= 1'b1;
      if (accept) filt <= s2;
      if (!armed || (s1 != s2) || accept || !pending) cnt <= LOAD;
      else cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/gray_quad_decoder.sv
// Gray/quadrature receive decoder: position tracking, direction and illegal-step flags.
//  state    | meaning
//  ST_INIT  | waiting for the first stable input value to seed filt
//  ST_TRACK | every acceptance is classified as up, down or illegal
module gray_quad_decoder
  import gray_quad_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f1_in,
  input  logic             f2_in,
  input  logic             clr,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_pulse,
  output logic             valid
);

  state_t           state, state_nxt;
  logic [1:0]       filt;
  logic [1:0]       cand;
  logic             accept;
  step_t            kind;
  logic [CNT_W-1:0] pos_nxt;
  logic             dir_nxt, step_nxt, err_nxt, err_pulse_nxt, valid_nxt;

  gray_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_in     ({f1_in, f2_in}),
    .capture_any (state == ST_INIT),
    .filt        (filt),
    .cand        (cand),
    .accept      (accept)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      pos       <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      dir       <= dir_nxt;
      step      <= step_nxt;
      err       <= err_nxt;
      err_pulse <= err_pulse_nxt;
      valid     <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pos_nxt       = pos;
    dir_nxt       = dir;
    step_nxt      = 1'b0;
    err_nxt       = err;
    err_pulse_nxt = 1'b0;
    valid_nxt     = valid;
    kind          = gray_step(filt, cand);
    case (state)
      ST_INIT: begin
        if (accept) begin
          state_nxt = ST_TRACK;
          valid_nxt = 1'b1;
        end
      end
      ST_TRACK: begin
        if (accept) begin
          case (kind)
            STEP_UP: begin
              pos_nxt  = pos + CNT_W'(1);
              dir_nxt  = 1'b1;
              step_nxt = 1'b1;
            end
            STEP_DOWN: begin
              pos_nxt  = pos - CNT_W'(1);
              dir_nxt  = 1'b0;
              step_nxt = 1'b1;
            end
            STEP_ILLEGAL: begin
              err_nxt       = 1'b1;
              err_pulse_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    // clr beats a coincident step on pos, but a coincident illegal event keeps err set.
    if (clr) begin
      pos_nxt = '0;
      if (!err_pulse_nxt) err_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_quad_decoder.sv
// Bench for gray_quad_decoder: window-based reference model checked every cycle plus directed literals.
module tb_gray_quad_decoder;

  localparam int W = 8;
  localparam int F = 2;

  logic         clk = 1'b0;
  logic         rst_n, f1_in, f2_in, clr;
  logic [W-1:0] pos;
  logic         dir, step, err, err_pulse, valid;

  gray_quad_decoder #(.CNT_W(W), .FILT_LEN(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f1_in     (f1_in),
    .f2_in     (f2_in),
    .clr       (clr),
    .pos       (pos),
    .dir       (dir),
    .step      (step),
    .err       (err),
    .err_pulse (err_pulse),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: s2 stream is the input delayed two edges; acceptance means the last F
  // synchronized samples after reset are identical (and differ from filt once tracking).
  logic [1:0]   m_s1 = 2'b00;
  logic [1:0]   wv [F];
  bit           wok [F];
  logic [1:0]   m_filt = 2'b00;
  bit           m_init = 1'b1;
  logic [W-1:0] m_pos = '0;
  bit           m_dir = 0, m_step = 0, m_err = 0, m_errp = 0, m_valid = 0;
  bit           chk_on = 0;

  function automatic int gidx(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    bit acc;
    int d;
    if (!rst_n) begin
      m_s1 = 2'b00;
      for (int i = 0; i < F; i++) wok[i] = 0;
      m_filt = 2'b00; m_init = 1;
      m_pos = '0; m_dir = 0; m_step = 0; m_err = 0; m_errp = 0; m_valid = 0;
    end else begin
      acc = 1;
      for (int i = 0; i < F; i++) if (!wok[i] || wv[i] != wv[0]) acc = 0;
      if (acc && !m_init && wv[0] == m_filt) acc = 0;
      m_step = 0; m_errp = 0;
      if (acc) begin
        if (m_init) begin
          m_init = 0; m_valid = 1;
        end else begin
          d = (gidx(wv[0]) - gidx(m_filt) + 4) % 4;
          if (d == 1) begin m_pos = m_pos + 1'b1; m_dir = 1; m_step = 1; end
          else if (d == 3) begin m_pos = m_pos - 1'b1; m_dir = 0; m_step = 1; end
          else if (d == 2) begin m_err = 1; m_errp = 1; end
        end
        m_filt = wv[0];
      end
      if (clr) begin
        m_pos = '0;
        if (!m_errp) m_err = 0;
      end
      for (int i = F - 1; i > 0; i--) begin wv[i] = wv[i-1]; wok[i] = wok[i-1]; end
      wv[0] = m_s1; wok[0] = 1;
      m_s1 = {f1_in, f2_in};
    end
  end

  int step_cnt = 0, errp_cnt = 0, step_run = 0, step_max = 0, errp_run = 0, errp_max = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_pos", 32'(pos), 32'(m_pos));
      check("cyc_dir", 32'(dir), 32'(m_dir));
      check("cyc_step", 32'(step), 32'(m_step));
      check("cyc_err", 32'(err), 32'(m_err));
      check("cyc_err_pulse", 32'(err_pulse), 32'(m_errp));
      check("cyc_valid", 32'(valid), 32'(m_valid));
    end
    if (step === 1'b1) begin step_cnt++; step_run++; end else step_run = 0;
    if (err_pulse === 1'b1) begin errp_cnt++; errp_run++; end else errp_run = 0;
    if (step_run > step_max) step_max = step_run;
    if (errp_run > errp_max) errp_max = errp_run;
  end

  task automatic drive(input logic [1:0] g, input int n);
    {f1_in, f2_in} = g;
    repeat (n) @(negedge clk);
  endtask

  int s0, e0;

  initial begin
    rst_n = 1'b0; clr = 1'b0; {f1_in, f2_in} = 2'b01;
    repeat (3) @(negedge clk);
    chk_on = 1;
    // Scenario 1: reset exit with 01 held; edge 0 is the first edge sampling rst_n=1.
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("init_valid_low", 32'(valid), 32'd0);
    @(negedge clk);
    check("init_valid_high", 32'(valid), 32'd1);
    check("init_pos", 32'(pos), 32'h00);
    drive(2'b01, 3);
    check("init_no_step", 32'(step_cnt), 32'd0);

    // Scenario 2: four up steps.
    s0 = step_cnt;
    drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5); drive(2'b01, 5);
    check("up_steps", 32'(step_cnt - s0), 32'd4);
    check("up_pulse_width", 32'(step_max), 32'd1);
    check("up_pos", 32'(pos), 32'h04);
    check("up_dir", 32'(dir), 32'd1);
    check("up_err", 32'(err), 32'd0);

    // Scenario 3: clear, then one down step wraps to all ones.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_pos", 32'(pos), 32'h00);
    s0 = step_cnt;
    drive(2'b00, 5);
    check("down_pos", 32'(pos), 32'hFF);
    check("down_dir", 32'(dir), 32'd0);
    check("down_steps", 32'(step_cnt - s0), 32'd1);

    // Scenario 4: up wrap, then a one-cycle glitch and an exactly-FILT_LEN hold.
    drive(2'b01, 5);
    check("wrap_up_pos", 32'(pos), 32'h00);
    s0 = step_cnt; e0 = errp_cnt;
    drive(2'b11, 1); drive(2'b01, 5);
    check("glitch_steps", 32'(step_cnt - s0), 32'd0);
    check("glitch_errs", 32'(errp_cnt - e0), 32'd0);
    check("glitch_pos", 32'(pos), 32'h00);
    drive(2'b11, 2); drive(2'b01, 5);
    check("edge_hold_steps", 32'(step_cnt - s0), 32'd2);
    check("edge_hold_dir", 32'(dir), 32'd0);

    // Scenario 5: illegal transition, legal step while err set, then clear.
    e0 = errp_cnt;
    drive(2'b10, 5);
    check("ill_pulses", 32'(errp_cnt - e0), 32'd1);
    check("ill_pulse_width", 32'(errp_max), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_pos", 32'(pos), 32'h00);
    drive(2'b00, 5);
    check("sticky_err", 32'(err), 32'd1);
    check("sticky_pos", 32'(pos), 32'h01);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr2_pos", 32'(pos), 32'h00);
    check("clr2_err", 32'(err), 32'd0);

    // clr coinciding with a legal step: step pulses, pos still cleared.
    {f1_in, f2_in} = 2'b01;
    repeat (3) @(negedge clk);
    clr = 1'b1; @(negedge clk);
    check("clr_step_pulse", 32'(step), 32'd1);
    check("clr_step_pos", 32'(pos), 32'h00);
    clr = 1'b0;
    drive(2'b01, 3);
    // clr coinciding with an illegal event: err wins.
    {f1_in, f2_in} = 2'b10;
    repeat (3) @(negedge clk);
    clr = 1'b1; @(negedge clk);
    check("clr_ill_pulse", 32'(err_pulse), 32'd1);
    check("clr_ill_err", 32'(err), 32'd1);
    clr = 1'b0;
    drive(2'b10, 3);
    clr = 1'b1; @(negedge clk); clr = 1'b0;

    // Scenario 6: reach pos=3, reset for one edge with a step pending, re-capture.
    drive(2'b00, 5); drive(2'b01, 5); drive(2'b11, 5);
    check("pre_rst_pos", 32'(pos), 32'h03);
    check("pre_rst_dir", 32'(dir), 32'd1);
    s0 = step_cnt;
    {f1_in, f2_in} = 2'b10;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pos", 32'(pos), 32'h00);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("recap_valid_low", 32'(valid), 32'd0);
    @(negedge clk);
    check("recap_valid_high", 32'(valid), 32'd1);
    check("recap_pos", 32'(pos), 32'h00);
    drive(2'b10, 4);
    check("recap_no_step", 32'(step_cnt - s0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
